// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for a simple accumulator CPU.
// Control strobes are decoded combinationally from the registered phase, halted flag, opcode and zero.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       data_e,
    output logic       halt
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] P_INST_ADDR  = 3'd0;
    localparam logic [2:0] P_INST_FETCH = 3'd1;
    localparam logic [2:0] P_INST_LOAD  = 3'd2;
    localparam logic [2:0] P_IDLE       = 3'd3;
    localparam logic [2:0] P_OP_ADDR    = 3'd4;
    localparam logic [2:0] P_OP_FETCH   = 3'd5;
    localparam logic [2:0] P_ALU_OP     = 3'd6;
    localparam logic [2:0] P_STORE      = 3'd7;

    logic [2:0] phase_r;
    logic [2:0] phase_s;
    logic       halted_r;
    logic       halted_s;
    logic       aluop_s;
    logic       is_sto_s;
    logic       is_jmp_s;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    assign phase    = phase_r;
    assign aluop_s  = is_aluop(opcode);
    assign is_sto_s = (opcode == OP_STO);
    assign is_jmp_s = (opcode == OP_JMP);

    // State register: phase counter and sticky halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r  <= 3'd0;
            halted_r <= 1'b0;
        end else begin
            phase_r  <= phase_s;
            halted_r <= halted_s;
        end
    end

    // Next-state: advance every clock; HLT in OP_ADDR freezes the sequencer in that phase.
    always_comb begin
        phase_s  = phase_r;
        halted_s = halted_r;
        if (halted_r) begin
            phase_s = phase_r;
        end else if ((phase_r == P_OP_ADDR) && (opcode == OP_HLT)) begin
            halted_s = 1'b1;
        end else begin
            phase_s = phase_r + 3'd1;
        end
    end

    // Output decode; reset forces every strobe low regardless of the registered state.
    always_comb begin
        sel     = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        data_e  = 1'b0;
        halt    = 1'b0;
        if (rst) begin
            halt = 1'b0;
        end else if (halted_r) begin
            halt = 1'b1;
        end else begin
            case (phase_r)
                P_INST_ADDR: begin
                    sel = 1'b1;
                end
                P_INST_FETCH: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                end
                P_INST_LOAD, P_IDLE: begin
                    sel     = 1'b1;
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                P_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                P_OP_FETCH: begin
                    mem_rd = aluop_s;
                end
                P_ALU_OP: begin
                    mem_rd  = aluop_s;
                    inc_pc  = (opcode == OP_SKZ) && zero;
                    load_pc = is_jmp_s;
                    data_e  = is_sto_s;
                end
                P_STORE: begin
                    mem_rd  = aluop_s;
                    load_ac = aluop_s;
                    load_pc = is_jmp_s;
                    data_e  = is_sto_s;
                    mem_wr  = is_sto_s;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed scoreboard bench for cpu_controller: the driver queues hand-computed
// phase/strobe expectations each cycle and a negedge monitor pops and compares them.
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    // Strobe vector order: {sel, mem_rd, load_ir, inc_pc, load_ac, load_pc, data_e, mem_wr, halt}
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_P0   = 9'b100000000;
    localparam logic [8:0] C_P1   = 9'b110000000;
    localparam logic [8:0] C_P23  = 9'b111000000;
    localparam logic [8:0] C_P4   = 9'b000100000;
    localparam logic [8:0] C_RD   = 9'b010000000;
    localparam logic [8:0] C_RDAC = 9'b010010000;
    localparam logic [8:0] C_DE   = 9'b000000100;
    localparam logic [8:0] C_DEWR = 9'b000000110;
    localparam logic [8:0] C_INC  = 9'b000100000;
    localparam logic [8:0] C_LDPC = 9'b000001000;
    localparam logic [8:0] C_HLT4 = 9'b000100001;
    localparam logic [8:0] C_HALT = 9'b000000001;

    typedef struct packed {
        logic [2:0] ph;
        logic [8:0] ctrl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, data_e, halt;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    logic done   = 1'b0;

    cpu_controller dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .zero    (zero),
        .phase   (phase),
        .sel     (sel),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .inc_pc  (inc_pc),
        .load_pc (load_pc),
        .data_e  (data_e),
        .halt    (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] got;
        cyc++;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {sel, mem_rd, load_ir, inc_pc, load_ac, load_pc, data_e, mem_wr, halt};
            checks++;
            if (phase === e.ph) passes++;
            else $display("FAIL phase cyc=%0d got=%0d want=%0d", cyc, phase, e.ph);
            checks++;
            if (got === e.ctrl) passes++;
            else $display("FAIL strobes cyc=%0d phase=%0d got=%b want=%b", cyc, e.ph, got, e.ctrl);
        end
    end

    // Drive one cycle of inputs (just after posedge) and queue the expected outputs.
    task automatic step(input logic r, input logic [2:0] op, input logic z,
                        input logic [2:0] ph, input logic [8:0] ctrl);
        exp_t e;
        rst    = r;
        opcode = op;
        zero   = z;
        e.ph   = ph;
        e.ctrl = ctrl;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Run the first n phases of an instruction; op_early is driven during fetch to show it is ignored.
    task automatic run_instr(input logic [2:0] op_early, input logic [2:0] op, input logic z,
                             input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7,
                             input int n);
        for (int p = 0; p < n; p++) begin
            case (p)
                0:       step(1'b0, op_early, z, 3'(p), C_P0);
                1:       step(1'b0, op_early, z, 3'(p), C_P1);
                2, 3:    step(1'b0, op_early, z, 3'(p), C_P23);
                4:       step(1'b0, op, z, 3'(p), C_P4);
                5:       step(1'b0, op, z, 3'(p), e5);
                6:       step(1'b0, op, z, 3'(p), e6);
                default: step(1'b0, op, z, 3'(p), e7);
            endcase
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = ADD;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        // Held in reset: phase 0, every strobe low
        step(1'b1, ADD, 1'b0, 3'd0, C_NONE);
        step(1'b1, JMP, 1'b1, 3'd0, C_NONE);

        // Arithmetic-class ops, zero ignored, fetch-phase opcode ignored, wrap 7->0 between them
        run_instr(ADD, ADD, 1'b0, C_RD, C_RD, C_RDAC, 8);
        run_instr(HLT, AND, 1'b1, C_RD, C_RD, C_RDAC, 8);
        run_instr(STO, XOR, 1'b0, C_RD, C_RD, C_RDAC, 8);
        run_instr(JMP, LDA, 1'b1, C_RD, C_RD, C_RDAC, 8);
        run_instr(ADD, STO, 1'b1, C_NONE, C_DE, C_DEWR, 8);
        run_instr(SKZ, SKZ, 1'b1, C_NONE, C_INC, C_NONE, 8);
        run_instr(SKZ, SKZ, 1'b0, C_NONE, C_NONE, C_NONE, 8);
        run_instr(HLT, JMP, 1'b1, C_NONE, C_LDPC, C_LDPC, 8);

        // Halt: phase freezes at 4, opcode changes have no effect
        run_instr(ADD, ADD, 1'b0, C_NONE, C_NONE, C_NONE, 4);
        step(1'b0, HLT, 1'b0, 3'd4, C_HLT4);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i % 2 == 0) ? ADD : JMP, i[0], 3'd4, C_HALT);
        end
        // Reset edge while halted: strobes drop immediately, phase clears at the edge
        step(1'b1, ADD, 1'b0, 3'd4, C_NONE);
        run_instr(ADD, ADD, 1'b0, C_RD, C_RD, C_RDAC, 8);

        // Reset in ALU_OP of a JMP aborts it; sequencing restarts at phase 0
        run_instr(JMP, JMP, 1'b0, C_NONE, C_LDPC, C_LDPC, 6);
        step(1'b1, JMP, 1'b0, 3'd6, C_NONE);
        run_instr(JMP, JMP, 1'b0, C_NONE, C_LDPC, C_LDPC, 3);

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL drain left=%0d want=0", sb.size());
        done = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog time=%0t", $time);
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 opcode  input  opcodeT (3)  instruction-register opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-004 zero  input  1  ALU accumulator-zero flag.
REQ-005 phase  output  3  current sequencer phase, 0..7.
REQ-006 sel  output  1  address mux select: 1=PC, 0=IR operand.
REQ-007 mem_rd  output  1  memory read strobe.
REQ-008 mem_wr  output  1  memory write strobe.
REQ-009 load_ir  output  1  instruction register load enable.
REQ-010 load_ac  output  1  accumulator load enable.
REQ-011 inc_pc  output  1  program counter increment enable.
REQ-012 load_pc  output  1  program counter load enable.
REQ-013 data_e  output  1  data bus output enable, for accumulator onto memory bus.
REQ-014 halt  output  1  CPU halted indication.

Function
REQ-015 Internal 3-bit phase counter SHALL advance by 1 each posedge clk, wrapping 7->0, unless rst or halted.
REQ-016 Phase names SHALL be: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE; one full instruction = 8 clocks.
REQ-017 Control outputs SHALL be combinational decode of registered phase, halted flag, opcode and zero; no extra latency.
REQ-018 ALUOP SHALL denote opcode in {ADD, AND, XOR, LDA}.
REQ-019 sel SHALL be 1 in phases 0-3, 0 in phases 4-7.
REQ-020 mem_rd SHALL be 1 in phases 1-3; in phases 5-7 it SHALL equal ALUOP; 0 otherwise.
REQ-021 load_ir SHALL be 1 in phases 2-3 only.
REQ-022 inc_pc SHALL be 1 in phase 4; in phase 6 it SHALL equal (opcode==SKZ && zero); 0 otherwise.
REQ-023 load_pc SHALL equal (opcode==JMP) in phases 6-7; 0 otherwise.
REQ-024 data_e SHALL equal (opcode==STO) in phases 6-7; mem_wr SHALL equal (opcode==STO) in phase 7 only.
REQ-025 load_ac SHALL equal ALUOP in phase 7 only.
REQ-026 In phase 4 with opcode==HLT, halt SHALL be 1 combinationally and halted flag SHALL set at that posedge.
REQ-027 While halted: phase SHALL freeze at 4 (no advance); halt=1; all other strobes (mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, data_e) SHALL be 0; sel=0.
REQ-028 Halted SHALL clear only by rst; opcode changes while halted SHALL have no effect.
REQ-029 SKZ with zero=0 SHALL produce no extra inc_pc; zero SHALL be ignored for all other opcodes.
REQ-030 Opcode SHALL be treated as don't-care in phases 0-3 (outputs independent of it).

Reset
REQ-031 On posedge clk with rst=1: phase<=0, halted<=0.
REQ-032 While rst=1 all control outputs SHALL be 0 and phase output SHALL read 0 after the first reset edge.
REQ-033 Reset asserted mid-instruction (any phase, halted or not) SHALL abort it; first post-reset cycle is phase 0 with sel=1, mem_rd=0.
REQ-034 After rst deasserts, phase 0->1 on the next posedge.

Verification
REQ-035 rst 2 cycles, release, opcode=ADD -> phases 0..7 in 8 clocks; mem_rd=1 in phases 1,2,3,5,6,7; load_ir in 2,3; inc_pc only in 4; load_ac only in 7; phase wraps 7->0.
REQ-036 opcode=STO -> mem_rd=0 in phases 5-7; data_e=1 in 6,7; mem_wr=1 in 7 only; load_ac=0 throughout.
REQ-037 opcode=SKZ: zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 in phase 4 only.
REQ-038 opcode=JMP -> load_pc=1 in phases 6,7; inc_pc=1 in phase 4; mem_rd=0 in 5-7.
REQ-039 opcode=HLT -> halt=1 in phase 4; phase stays 4 for 20 further clocks with all other strobes 0 even after opcode changed to ADD; rst pulse -> phase 0, halt=0, sequencing resumes.
REQ-040 rst asserted in phase 6 with opcode=JMP -> next phase 0, load_pc=0; after release phases restart 0,1,2.
